// File: rtl/pc_unit.sv
// Program-counter unit for the multi-cycle MIPS core: prioritised next-PC
// selection, exception entry/return with EPC capture, and an update counter.
module pc_unit #(
   parameter int unsigned      WIDTH     = 32'd32,
   parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
   parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
   parameter int unsigned      INC       = 32'd4,
   parameter int unsigned      CNT_W     = 32'd32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_write,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             jr,
   input  logic [WIDTH-1:0] jr_target,
   input  logic             exc_req,
   input  logic             eret,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus,
   output logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] bad_addr,
   output logic [1:0]       cause,
   output logic             exl,
   output logic [CNT_W-1:0] upd_cnt
);

   localparam logic [WIDTH-1:0] INC_V      = WIDTH'(INC);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 32'd1);
   localparam logic [WIDTH-1:0] ZERO_W     = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_EXT   = 2'd1;
   localparam logic [1:0] CAUSE_ALIGN = 2'd2;

   // INC is a power of two, so any low bit under the mask means misalignment.
   function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
      return |(addr & ALIGN_MASK);
   endfunction

   logic [WIDTH-1:0] pc_r;
   logic [WIDTH-1:0] epc_r;
   logic [WIDTH-1:0] bad_addr_r;
   logic [1:0]       cause_r;
   logic             exl_r;
   logic [CNT_W-1:0] upd_cnt_r;

   logic [WIDTH-1:0] pc_plus_s;
   logic [WIDTH-1:0] target_s;
   logic             misalign_s;
   logic             eret_ok_s;

   logic [WIDTH-1:0] pc_nxt_s;
   logic [WIDTH-1:0] epc_nxt_s;
   logic [WIDTH-1:0] bad_addr_nxt_s;
   logic [1:0]       cause_nxt_s;
   logic             exl_nxt_s;
   logic [CNT_W-1:0] upd_cnt_nxt_s;

   assign pc_plus_s = pc_r + INC_V;

   // Redirect target selection: jr beats jmp beats taken branch beats sequential.
   always_comb begin
      target_s = pc_plus_s;
      if (jr) begin
         target_s = jr_target;
      end else if (jmp) begin
         target_s = jmp_target;
      end else if (br_taken) begin
         target_s = br_target;
      end else begin
         target_s = pc_plus_s;
      end
   end

   assign misalign_s = is_misaligned(target_s);
   assign eret_ok_s  = pc_write & eret & exl_r;

   // Next-state computation for all architectural PC state.
   always_comb begin
      pc_nxt_s       = pc_r;
      epc_nxt_s      = epc_r;
      bad_addr_nxt_s = bad_addr_r;
      cause_nxt_s    = cause_r;
      exl_nxt_s      = exl_r;
      upd_cnt_nxt_s  = upd_cnt_r;

      if (exc_req) begin
         pc_nxt_s    = EXC_VEC;
         cause_nxt_s = CAUSE_EXT;
         exl_nxt_s   = 1'b1;
         // A nested exception keeps the EPC of the outermost one.
         if (!exl_r) begin
            epc_nxt_s = pc_r;
         end else begin
            epc_nxt_s = epc_r;
         end
      end else if (eret_ok_s) begin
         pc_nxt_s    = epc_r;
         exl_nxt_s   = 1'b0;
         cause_nxt_s = CAUSE_NONE;
      end else if (pc_write) begin
         if (misalign_s) begin
            pc_nxt_s       = EXC_VEC;
            bad_addr_nxt_s = target_s;
            cause_nxt_s    = CAUSE_ALIGN;
            exl_nxt_s      = 1'b1;
            if (!exl_r) begin
               epc_nxt_s = pc_r;
            end else begin
               epc_nxt_s = epc_r;
            end
         end else begin
            pc_nxt_s      = target_s;
            upd_cnt_nxt_s = upd_cnt_r + CNT_ONE;
         end
      end else begin
         pc_nxt_s = pc_r;
      end
   end

   // State register with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r       <= RESET_VEC;
         epc_r      <= ZERO_W;
         bad_addr_r <= ZERO_W;
         cause_r    <= CAUSE_NONE;
         exl_r      <= 1'b0;
         upd_cnt_r  <= CNT_ZERO;
      end else begin
         pc_r       <= pc_nxt_s;
         epc_r      <= epc_nxt_s;
         bad_addr_r <= bad_addr_nxt_s;
         cause_r    <= cause_nxt_s;
         exl_r      <= exl_nxt_s;
         upd_cnt_r  <= upd_cnt_nxt_s;
      end
   end

   assign pc_out   = pc_r;
   assign pc_plus  = pc_plus_s;
   assign epc      = epc_r;
   assign bad_addr = bad_addr_r;
   assign cause    = cause_r;
   assign exl      = exl_r;
   assign upd_cnt  = upd_cnt_r;

endmodule
